// File: rtl/boot_ram_loader.sv
// Boot RAM loader: parses a 4-byte header, streams little-endian words
// into the boot RAM and releases the CPU reset once the checksum matches.
module boot_ram_loader #(
   parameter logic [7:0] MAGIC     = 8'hA5,
   parameter int         MAX_WORDS = 512
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        start,
   input  logic [7:0]  in_data,
   input  logic        in_valid,
   output logic        in_ready,
   output logic [8:0]  ram_address,
   output logic [3:0]  ram_byteenable,
   output logic        ram_chipselect,
   output logic        ram_write,
   output logic [31:0] ram_writedata,
   output logic        busy,
   output logic        done,
   output logic        error,
   output logic        cpu_reset_req,
   output logic [9:0]  words_loaded
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_HDR,
      S_LOAD,
      S_CHECK,
      S_DONE,
      S_ERROR
   } state_t;

   localparam logic [10:0] MAXW = 11'(MAX_WORDS);

   state_t      state_q;
   logic [1:0]  byte_cnt_q;
   logic [7:0]  b0_q;
   logic [7:0]  cnt_lo_q;
   logic [9:0]  count_q;
   logic [7:0]  cks_exp_q;
   logic [7:0]  cks_q;
   logic [23:0] asm_q;
   logic [31:0] wdata_q;
   logic        wr_q;
   logic [9:0]  words_q;

   logic        xfer;
   logic [9:0]  hdr_count;
   logic        hdr_bad;
   logic        last_word;

   assign xfer      = in_valid & in_ready;
   assign hdr_count = {in_data[1:0], cnt_lo_q};
   assign hdr_bad   = (b0_q != MAGIC)
                    | (in_data[7:2] != 6'd0)
                    | (hdr_count == 10'd0)
                    | ({1'b0, hdr_count} > MAXW);
   // words_q still holds the count of words written before this one
   assign last_word = (words_q + 10'd1) == count_q;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= S_IDLE;
         byte_cnt_q <= '0;
         b0_q       <= '0;
         cnt_lo_q   <= '0;
         count_q    <= '0;
         cks_exp_q  <= '0;
         cks_q      <= '0;
         asm_q      <= '0;
         wdata_q    <= '0;
         wr_q       <= 1'b0;
         words_q    <= '0;
      end else begin
         if (wr_q) begin
            wr_q    <= 1'b0;
            words_q <= words_q + 10'd1;
         end
         case (state_q)
            S_IDLE, S_DONE, S_ERROR: begin
               if (start) begin
                  state_q    <= S_HDR;
                  words_q    <= '0;
                  byte_cnt_q <= '0;
                  cks_q      <= '0;
               end
            end
            S_HDR: begin
               if (xfer) begin
                  byte_cnt_q <= byte_cnt_q + 2'd1;
                  case (byte_cnt_q)
                     2'd0: b0_q <= in_data;
                     2'd1: cnt_lo_q <= in_data;
                     2'd2: begin
                        if (hdr_bad) state_q <= S_ERROR;
                        else count_q <= hdr_count;
                     end
                     default: begin
                        cks_exp_q <= in_data;
                        state_q   <= S_LOAD;
                     end
                  endcase
               end
            end
            S_LOAD: begin
               if (xfer) begin
                  cks_q      <= cks_q ^ in_data;
                  byte_cnt_q <= byte_cnt_q + 2'd1;
                  case (byte_cnt_q)
                     2'd0: asm_q[7:0]   <= in_data;
                     2'd1: asm_q[15:8]  <= in_data;
                     2'd2: asm_q[23:16] <= in_data;
                     default: begin
                        wdata_q <= {in_data, asm_q};
                        wr_q    <= 1'b1;
                        if (last_word) state_q <= S_CHECK;
                     end
                  endcase
               end
            end
            S_CHECK: begin
               if (cks_q == cks_exp_q) state_q <= S_DONE;
               else state_q <= S_ERROR;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign in_ready       = (state_q == S_HDR) | (state_q == S_LOAD);
   assign busy           = in_ready | (state_q == S_CHECK);
   assign done           = (state_q == S_DONE);
   assign error          = (state_q == S_ERROR);
   assign cpu_reset_req  = (state_q != S_DONE);
   assign ram_address    = words_q[8:0];
   assign ram_byteenable = 4'hF;
   assign ram_chipselect = wr_q;
   assign ram_write      = wr_q;
   assign ram_writedata  = wdata_q;
   assign words_loaded   = words_q;

endmodule

// File: tb/tb_boot_ram_loader.sv
// Directed and randomized image loads checked against a header/payload
// reference model; every RAM write is captured and compared in order.
module tb_boot_ram_loader;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        start = 1'b0;
   logic [7:0]  in_data = 8'h00;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [8:0]  ram_address;
   logic [3:0]  ram_byteenable;
   logic        ram_chipselect;
   logic        ram_write;
   logic [31:0] ram_writedata;
   logic        busy;
   logic        done;
   logic        error;
   logic        cpu_reset_req;
   logic [9:0]  words_loaded;

   boot_ram_loader dut (
      .clk            (clk),
      .reset_n        (reset_n),
      .start          (start),
      .in_data        (in_data),
      .in_valid       (in_valid),
      .in_ready       (in_ready),
      .ram_address    (ram_address),
      .ram_byteenable (ram_byteenable),
      .ram_chipselect (ram_chipselect),
      .ram_write      (ram_write),
      .ram_writedata  (ram_writedata),
      .busy           (busy),
      .done           (done),
      .error          (error),
      .cpu_reset_req  (cpu_reset_req),
      .words_loaded   (words_loaded)
   );

   always #5 clk = ~clk;

   int vectors = 0;
   int miscompares = 0;

   logic [7:0]  img[$];
   logic [8:0]  obs_a[$];
   logic [31:0] obs_d[$];
   logic [8:0]  exp_a[$];
   logic [31:0] exp_d[$];
   bit          exp_done;
   bit          exp_err;
   int          exp_words;
   int          nsend;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   always @(negedge clk) begin
      if (reset_n && (ram_write || ram_chipselect)) begin
         chk("wr_strobe", ram_write, 1'b1);
         chk("cs_strobe", ram_chipselect, 1'b1);
         chk("byteen", ram_byteenable, 4'hF);
         obs_a.push_back(ram_address);
         obs_d.push_back(ram_writedata);
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [7:0] b);
      int n;
      n = 0;
      in_data  = b;
      in_valid = 1'b1;
      while (!in_ready && n < 20) begin
         step();
         n++;
      end
      if (!in_ready) chk("send_timeout", 1'b0, 1'b1);
      else step();
      in_valid = 1'b0;
      start    = 1'b0;
   endtask

   // Expected outcome straight from the header rules and payload bytes.
   task automatic model();
      logic [9:0] cnt;
      logic [7:0] x;
      bit         bad;
      exp_a.delete();
      exp_d.delete();
      cnt = {img[2][1:0], img[1]};
      bad = (img[0] != 8'hA5) || (img[2][7:2] != 6'd0)
         || (cnt == 10'd0) || (cnt > 10'd512);
      if (bad) begin
         exp_err   = 1;
         exp_done  = 0;
         exp_words = 0;
         nsend     = 3;
      end else begin
         x = 8'h00;
         for (int w = 0; w < int'(cnt); w++) begin
            exp_a.push_back(w[8:0]);
            exp_d.push_back({img[4+4*w+3], img[4+4*w+2],
                             img[4+4*w+1], img[4+4*w]});
            for (int k = 0; k < 4; k++) x ^= img[4+4*w+k];
         end
         exp_done  = (x == img[3]);
         exp_err   = !exp_done;
         exp_words = int'(cnt);
         nsend     = 4 + 4 * int'(cnt);
      end
   endtask

   task automatic make_good(input int cnt, input bit corrupt);
      logic [9:0] c;
      logic [7:0] x;
      logic [7:0] b;
      c = cnt[9:0];
      img.delete();
      img.push_back(8'hA5);
      img.push_back(c[7:0]);
      img.push_back({6'd0, c[9:8]});
      img.push_back(8'h00);
      x = 8'h00;
      for (int i = 0; i < 4 * cnt; i++) begin
         b = 8'($urandom);
         img.push_back(b);
         x ^= b;
      end
      img[3] = corrupt ? (x ^ 8'h5A) : x;
   endtask

   task automatic cmp_writes(input string tag, input int n);
      chk({tag, "_nwr"}, obs_a.size(), n);
      for (int i = 0; i < n && i < obs_a.size(); i++) begin
         chk({tag, "_addr"}, obs_a[i], exp_a[i]);
         chk({tag, "_data"}, obs_d[i], exp_d[i]);
      end
   endtask

   task automatic run_load(input string tag, input bit gaps,
                           input bit mid_start);
      int n;
      model();
      obs_a.delete();
      obs_d.delete();
      start = 1'b1;
      step();
      start = 1'b0;
      for (int i = 0; i < nsend; i++) begin
         if (gaps && $urandom_range(0, 3) > 1)
            repeat ($urandom_range(1, 3)) step();
         if (mid_start && i == nsend / 2 && nsend > 8) start = 1'b1;
         send(img[i]);
         if (i == 3 && nsend > 4) chk({tag, "_busy"}, busy, 1'b1);
      end
      n = 0;
      while (!(done || error) && n < 50) begin
         step();
         n++;
      end
      chk({tag, "_term"}, done | error, 1'b1);
      repeat (3) step();
      chk({tag, "_done"}, done, exp_done);
      chk({tag, "_err"}, error, exp_err);
      chk({tag, "_cpurst"}, cpu_reset_req, !exp_done);
      chk({tag, "_words"}, words_loaded, exp_words);
      chk({tag, "_busy_end"}, busy, 1'b0);
      chk({tag, "_rdy_end"}, in_ready, 1'b0);
      cmp_writes(tag, exp_a.size());
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, "_rdy"}, in_ready, 1'b0);
      chk({tag, "_busy"}, busy, 1'b0);
      chk({tag, "_done"}, done, 1'b0);
      chk({tag, "_err"}, error, 1'b0);
      chk({tag, "_cs"}, ram_chipselect, 1'b0);
      chk({tag, "_wr"}, ram_write, 1'b0);
      chk({tag, "_addr"}, ram_address, 9'd0);
      chk({tag, "_wdata"}, ram_writedata, 32'd0);
      chk({tag, "_be"}, ram_byteenable, 4'hF);
      chk({tag, "_cpurst"}, cpu_reset_req, 1'b1);
      chk({tag, "_words"}, words_loaded, 10'd0);
   endtask

   initial begin
      #3;
      chk_reset("rst0");
      repeat (2) step();
      reset_n = 1'b1;
      step();
      chk_reset("idle");

      // in_valid with in_ready low must do nothing
      obs_a.delete();
      for (int i = 0; i < 4; i++) begin
         in_data  = 8'hA5;
         in_valid = 1'b1;
         step();
      end
      in_valid = 1'b0;
      chk("idle_valid_busy", busy, 1'b0);
      chk("idle_valid_nwr", obs_a.size(), 0);

      img = '{8'hA5, 8'h02, 8'h00, 8'h88, 8'h11, 8'h22, 8'h33, 8'h44,
              8'h55, 8'h66, 8'h77, 8'h88};
      run_load("basic", 0, 0);
      chk("basic_d0", obs_d.size() > 0 ? obs_d[0] : 32'hx, 32'h44332211);
      chk("basic_d1", obs_d.size() > 1 ? obs_d[1] : 32'hx, 32'h88776655);

      img = '{8'h5A, 8'h01, 8'h00, 8'h00};
      run_load("badmagic", 0, 0);
      img = '{8'hA5, 8'h00, 8'h00, 8'h00};
      run_load("cnt0", 0, 0);
      img = '{8'hA5, 8'h01, 8'h02, 8'h00};
      run_load("cnt513", 0, 0);
      img = '{8'hA5, 8'h01, 8'h04, 8'h00};
      run_load("b2rsvd", 0, 0);
      img = '{8'hA5, 8'h01, 8'h00, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00};
      run_load("badcks", 0, 0);

      for (int t = 0; t < 8; t++) begin
         make_good($urandom_range(1, 8), t % 3 == 2);
         run_load("rand", 1, t % 2 == 1);
      end

      make_good(512, 0);
      run_load("full512", 1, 0);

      // reset in the middle of a 10-word load
      make_good(10, 0);
      model();
      obs_a.delete();
      obs_d.delete();
      start = 1'b1;
      step();
      start = 1'b0;
      for (int i = 0; i < 16; i++) send(img[i]);
      repeat (2) step();
      cmp_writes("pre_rst", 3);
      #2;
      reset_n = 1'b0;
      #1;
      chk_reset("midrst");
      obs_a.delete();
      obs_d.delete();
      for (int i = 16; i < 20; i++) begin
         in_data  = img[i];
         in_valid = 1'b1;
         step();
      end
      in_valid = 1'b0;
      reset_n  = 1'b1;
      for (int i = 20; i < 24; i++) begin
         in_data  = img[i];
         in_valid = 1'b1;
         step();
      end
      in_valid = 1'b0;
      chk("post_rst_nwr", obs_a.size(), 0);
      chk("post_rst_words", words_loaded, 10'd0);
      make_good(10, 0);
      run_load("reload", 1, 0);

      $display("== %0d vectors applied, %0d miscompares ==",
               vectors, miscompares);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

endmodule
